// File: rtl/coll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coll_pkg
//  Description : Shared types and constants for the collision pair scheduler
//                and the 16-bit collision detector it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package coll_pkg;

   // Operand width of the collision detector
   localparam int W = 16;

   // Edges the detector consumes per transaction while in_rdy is high
   localparam int DET_STEPS = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Number of unordered pairs (i<j) among n bodies
   function automatic int num_pairs(input int n);
      return (n < 2) ? 0 : (n * (n - 1)) / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/coll_pair_sched_pair_iter.sv
`default_nettype none
// ============================================================================
//  Module      : pair_iter
//  Description : Triangular (i,j) counter walking every pair i<j of N items.
//                Exposes the current pair, the pair after an advance, and a
//                flag marking the final pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_iter #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic [IW-1:0] nxt_i,
   output logic [IW-1:0] nxt_j,
   output logic          last
);

   localparam logic [IW-1:0] LAST_I = IW'(N - 2);
   localparam logic [IW-1:0] LAST_J = IW'(N - 1);

   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] j_q, j_d;

   // Successor pair: step j, or wrap to the next row starting at i+1
   always_comb begin
      if (j_q == LAST_J) begin
         nxt_i = i_q + IW'(1);
         nxt_j = i_q + IW'(2);
      end else begin
         nxt_i = i_q;
         nxt_j = j_q + IW'(1);
      end
   end

   // Next-state selection: clear wins over advance
   always_comb begin
      i_d = i_q;
      j_d = j_q;
      if (clear) begin
         i_d = '0;
         j_d = IW'(1);
      end else if (advance) begin
         i_d = nxt_i;
         j_d = nxt_j;
      end
   end

   // Pair registers
   always_ff @(posedge clock) begin
      if (reset) begin
         i_q <= '0;
         j_q <= IW'(1);
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

   assign i    = i_q;
   assign j    = j_q;
   assign last = (N < 2) || ((i_q == LAST_I) && (j_q == LAST_J));

endmodule
`default_nettype wire

// File: rtl/coll_pair_sched.sv
`default_nettype none
// ============================================================================
//  Module      : coll_pair_sched
//  Description : Sweeps all body pairs through the collision detector, one
//                10-edge detector transaction per pair, and streams each
//                pair's result out as a tagged hit record.
//  Revision    : 1.0 - initial release
// ============================================================================
module coll_pair_sched
   import coll_pkg::*;
#(
   parameter  int N_BODIES = 8,
   parameter  int W        = coll_pkg::W,
   localparam int IW       = (N_BODIES > 1) ? $clog2(N_BODIES) : 1,
   localparam int NP       = num_pairs(N_BODIES),
   localparam int HCW      = (NP > 0) ? $clog2(NP + 1) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic [IW-1:0]  load_idx,
   input  logic [W-1:0]   load_x,
   input  logic [W-1:0]   load_y,
   input  logic [W-1:0]   load_vx,
   input  logic [W-1:0]   load_vy,
   input  logic [W-1:0]   r2_in,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [W-1:0]   x1,
   output logic [W-1:0]   y1,
   output logic [W-1:0]   x2,
   output logic [W-1:0]   y2,
   output logic [W-1:0]   vx1,
   output logic [W-1:0]   vy1,
   output logic [W-1:0]   vx2,
   output logic [W-1:0]   vy2,
   output logic [W-1:0]   r2,
   output logic           in_rdy,
   input  logic           trial,
   input  logic           out_rdy,
   output logic           hit_valid,
   output logic [IW-1:0]  hit_i,
   output logic [IW-1:0]  hit_j,
   output logic           hit,
   output logic [HCW-1:0] hit_count
);

   localparam int MW = $clog2(DET_STEPS);
   localparam logic [MW-1:0] M_LAST = MW'(DET_STEPS - 1);

   // Body record packed as {vy, vx, y, x}
   logic [4*W-1:0] mem_q [N_BODIES];
   logic [4*W-1:0] mem_d [N_BODIES];

   state_e         state_q, state_d;
   logic [MW-1:0]  m_q, m_d;
   logic           in_rdy_q, in_rdy_d;
   logic [W-1:0]   r2_q, r2_d;
   logic [4*W-1:0] opa_q, opa_d, opb_q, opb_d;
   logic           hit_valid_q, hit_valid_d;
   logic           hit_q, hit_d;
   logic [IW-1:0]  hit_i_q, hit_i_d, hit_j_q, hit_j_d;
   logic [HCW-1:0] hit_count_q, hit_count_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   logic           it_clear, it_adv, it_last, ld_ops, load_ok;
   logic [IW-1:0]  it_i, it_j, it_ni, it_nj, sel_a, sel_b;

   pair_iter #(.N(N_BODIES), .IW(IW)) u_iter (
      .clock   (clock),
      .reset   (reset),
      .clear   (it_clear),
      .advance (it_adv),
      .i       (it_i),
      .j       (it_j),
      .nxt_i   (it_ni),
      .nxt_j   (it_nj),
      .last    (it_last)
   );

   assign load_ok = ({1'b0, load_idx} < (IW + 1)'(N_BODIES));

   // Sweep FSM, body memory writes, operand loading and result capture
   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      in_rdy_d    = in_rdy_q;
      r2_d        = r2_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      hit_valid_d = 1'b0;
      hit_d       = hit_q;
      hit_i_d     = hit_i_q;
      hit_j_d     = hit_j_q;
      hit_count_d = hit_count_q;
      err_d       = err_q;
      done_d      = 1'b0;
      mem_d       = mem_q;
      it_clear    = 1'b0;
      it_adv      = 1'b0;
      ld_ops      = 1'b0;
      sel_a       = '0;
      sel_b       = IW'(1);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               r2_d        = r2_in;
               hit_count_d = '0;
               err_d       = 1'b0;
               m_d         = '0;
               it_clear    = 1'b1;
               if (N_BODIES < 2) begin
                  state_d = ST_DONE;
               end else begin
                  ld_ops   = 1'b1;
                  in_rdy_d = 1'b1;
                  state_d  = ST_RUN;
               end
            end else if (load && load_ok) begin
               mem_d[load_idx] = {load_vy, load_vx, load_y, load_x};
            end
         end
         ST_RUN: begin
            m_d = m_q + MW'(1);
            if (m_q == M_LAST) begin
               in_rdy_d = 1'b0;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (out_rdy) begin
               hit_valid_d = 1'b1;
               hit_d       = trial;
               hit_i_d     = it_i;
               hit_j_d     = it_j;
               if (trial && (hit_count_q != HCW'(NP))) begin
                  hit_count_d = hit_count_q + HCW'(1);
               end
               if (it_last) begin
                  state_d = ST_DONE;
               end else begin
                  it_adv   = 1'b1;
                  sel_a    = it_ni;
                  sel_b    = it_nj;
                  ld_ops   = 1'b1;
                  in_rdy_d = 1'b1;
                  m_d      = '0;
                  state_d  = ST_RUN;
               end
            end else begin
               // Detector not ready where the mirror counter says it must be
               err_d    = 1'b1;
               in_rdy_d = 1'b0;
               state_d  = ST_DONE;
            end
         end
         default: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      if (ld_ops) begin
         opa_d = mem_q[sel_a];
         opb_d = mem_q[sel_b];
      end
   end

   // State, memory and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         m_q         <= '0;
         in_rdy_q    <= 1'b0;
         r2_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         hit_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_i_q     <= '0;
         hit_j_q     <= '0;
         hit_count_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         for (int b = 0; b < N_BODIES; b++) mem_q[b] <= '0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         in_rdy_q    <= in_rdy_d;
         r2_q        <= r2_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         hit_valid_q <= hit_valid_d;
         hit_q       <= hit_d;
         hit_i_q     <= hit_i_d;
         hit_j_q     <= hit_j_d;
         hit_count_q <= hit_count_d;
         err_q       <= err_d;
         done_q      <= done_d;
         mem_q       <= mem_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign in_rdy    = in_rdy_q;
   assign r2        = r2_q;
   assign x1        = opa_q[W-1:0];
   assign y1        = opa_q[2*W-1:W];
   assign vx1       = opa_q[3*W-1:2*W];
   assign vy1       = opa_q[4*W-1:3*W];
   assign x2        = opb_q[W-1:0];
   assign y2        = opb_q[2*W-1:W];
   assign vx2       = opb_q[3*W-1:2*W];
   assign vy2       = opb_q[4*W-1:3*W];
   assign hit_valid = hit_valid_q;
   assign hit       = hit_q;
   assign hit_i     = hit_i_q;
   assign hit_j     = hit_j_q;
   assign hit_count = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_coll_pair_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coll_pair_sched
//  Description : Directed bench for coll_pair_sched with a 10-step stub
//                detector (trial = x1==x2); N=4 and N=1 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coll_pair_sched;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [1:0]  load_idx = '0;
   logic [15:0] load_x = '0, load_y = '0, load_vx = '0, load_vy = '0;
   logic [15:0] r2_in = 16'h0042;
   logic        start = 1'b0;
   logic        start_b = 1'b0;
   logic        kill_en = 1'b0;

   logic        busy, done, err, in_rdy, trial, out_rdy, hit_valid, hit;
   logic [15:0] x1, y1, x2, y2, vx1, vy1, vx2, vy2, r2;
   logic [1:0]  hit_i, hit_j;
   logic [2:0]  hit_count;

   logic        busy_b, done_b, err_b, in_rdy_b, hit_valid_b, hit_b;
   logic [15:0] x1_b, y1_b, x2_b, y2_b, vx1_b, vy1_b, vx2_b, vy2_b, r2_b;
   logic        hit_i_b, hit_j_b, hit_count_b;

   int n_assert = 0;
   int n_fail   = 0;

   int ex[4]  = '{5, 5, 7, 5};
   int ey[4]  = '{10, 20, 30, 40};
   int evx[4] = '{1, 2, 3, 4};
   int evy[4] = '{9, 8, 7, 6};
   int pi[6]  = '{0, 0, 0, 1, 1, 2};
   int pj[6]  = '{1, 2, 3, 2, 3, 3};
   int eh[6]  = '{1, 0, 1, 0, 1, 0};

   // Stub detector state
   int stub_cnt = 0;
   int stub_txn = 0;

   always #5 clock = ~clock;

   coll_pair_sched #(.N_BODIES(4), .W(16)) dut (
      .clock(clock), .reset(reset), .load(load), .load_idx(load_idx),
      .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
      .r2_in(r2_in), .start(start), .busy(busy), .done(done), .err(err),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .vx1(vx1), .vy1(vy1), .vx2(vx2),
      .vy2(vy2), .r2(r2), .in_rdy(in_rdy), .trial(trial), .out_rdy(out_rdy),
      .hit_valid(hit_valid), .hit_i(hit_i), .hit_j(hit_j), .hit(hit),
      .hit_count(hit_count)
   );

   coll_pair_sched #(.N_BODIES(1), .W(16)) dut_b (
      .clock(clock), .reset(reset), .load(1'b0), .load_idx(1'b0),
      .load_x(16'h0), .load_y(16'h0), .load_vx(16'h0), .load_vy(16'h0),
      .r2_in(16'h0), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
      .x1(x1_b), .y1(y1_b), .x2(x2_b), .y2(y2_b), .vx1(vx1_b), .vy1(vy1_b),
      .vx2(vx2_b), .vy2(vy2_b), .r2(r2_b), .in_rdy(in_rdy_b), .trial(1'b0),
      .out_rdy(1'b0), .hit_valid(hit_valid_b), .hit_i(hit_i_b), .hit_j(hit_j_b),
      .hit(hit_b), .hit_count(hit_count_b)
   );

   // Stub: counts in_rdy edges, result ready after 10, frozen until next in_rdy
   always @(posedge clock) begin
      if (reset) begin
         stub_cnt <= 0;
         stub_txn <= 0;
      end else begin
         if (start && !busy) stub_txn <= 0;
         if (in_rdy) begin
            stub_cnt <= (stub_cnt == 10) ? 1 : stub_cnt + 1;
            if (stub_cnt == 9) stub_txn <= stub_txn + 1;
         end
      end
   end

   assign out_rdy = (stub_cnt == 10) && !(kill_en && stub_txn == 3);
   assign trial   = (x1 == x2);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_bodies();
      for (int b = 0; b < 4; b++) begin
         load     = 1'b1;
         load_idx = 2'(b);
         load_x   = 16'(ex[b]);
         load_y   = 16'(ey[b]);
         load_vx  = 16'(evx[b]);
         load_vy  = 16'(evy[b]);
         tick();
      end
      load = 1'b0;
   endtask

   // One sweep of the N=4 instance; kill>=0 withholds out_rdy in that pair's GAP
   task automatic sweep(input int kill);
      int np, done_cyc, train_end, k, hc;
      np        = (kill >= 0) ? kill : 6;
      done_cyc  = (kill >= 0) ? 11 * kill + 12 : 11 * 6 + 1;
      train_end = (kill >= 0) ? 11 * kill + 10 : 11 * 6;
      kill_en   = (kill >= 0);
      hc        = 0;
      // load together with start must be ignored
      start    = 1'b1;
      load     = 1'b1;
      load_idx = 2'd1;
      load_x   = 16'hdead;
      tick();
      start = 1'b0;
      load  = 1'b0;
      for (int cyc = 0; cyc <= done_cyc + 1; cyc++) begin
         // load while busy must be ignored
         if (cyc == 5) begin
            load     = 1'b1;
            load_idx = 2'd0;
            load_x   = 16'h0099;
         end
         if (cyc == 6) load = 1'b0;
         k = cyc / 11;
         chk("in_rdy", in_rdy, (cyc < train_end) && (cyc % 11 != 10));
         chk("busy", busy, cyc < done_cyc);
         chk("done", done, cyc == done_cyc);
         if (cyc == 0) begin
            chk("err_clr", err, 0);
            chk("hc_clr", hit_count, 0);
         end
         if (cyc < train_end && cyc % 11 == 0) begin
            chk("x1", x1, ex[pi[k]]);
            chk("x2", x2, ex[pj[k]]);
            chk("y1", y1, ey[pi[k]]);
            chk("y2", y2, ey[pj[k]]);
            chk("vx2", vx2, evx[pj[k]]);
            chk("vy1", vy1, evy[pi[k]]);
            chk("r2", r2, 32'h42);
         end else if (cyc < train_end && cyc % 11 != 10) begin
            chk("x1_hold", x1, ex[pi[k]]);
            chk("x2_hold", x2, ex[pj[k]]);
         end
         if (cyc > 0 && cyc % 11 == 0 && k - 1 < np) begin
            hc = hc + eh[k - 1];
            chk("hit_valid", hit_valid, 1);
            chk("hit_i", hit_i, pi[k - 1]);
            chk("hit_j", hit_j, pj[k - 1]);
            chk("hit", hit, eh[k - 1]);
            chk("hit_count", hit_count, hc);
         end else begin
            chk("hit_valid_lo", hit_valid, 0);
         end
         if (cyc == done_cyc) chk("err_end", err, kill >= 0);
         if (cyc <= done_cyc) tick();
      end
      kill_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_hc", hit_count, 0);
      chk("rst_x1", x1, 0);

      load_bodies();

      // Full sweep, error sweep, then a clean sweep that must clear err
      sweep(-1);
      sweep(2);
      chk("no_in_rdy_after_err", in_rdy, 0);
      sweep(-1);

      // N=1: straight to done, no transaction
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_busy0", busy_b, 1);
      chk("b_done0", done_b, 0);
      chk("b_in_rdy0", in_rdy_b, 0);
      tick();
      chk("b_done1", done_b, 1);
      chk("b_busy1", busy_b, 0);
      chk("b_hv1", hit_valid_b, 0);
      chk("b_in_rdy1", in_rdy_b, 0);
      tick();
      chk("b_done2", done_b, 0);

      // Reset in the RUN phase of pair 3
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (38) tick();
      chk("pre_rst_hc", hit_count, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_rdy", in_rdy, 0);
      chk("mid_rst_hc", hit_count, 0);

      // Memory was cleared: reload and sweep again with the stub reset alongside
      load_bodies();
      sweep(-1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
